// File: rtl/game_pkg.sv
// Shared types and widths for the game sequencer and its testbench.
package game_pkg;

  localparam int SCORE_W      = 4;
  localparam int FRAME_CNT_W  = 8;
  localparam int KEYS_W       = 2;
  localparam int X_POS_W      = 10;
  localparam int SCREEN_H_RES = 640;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

endpackage

// File: rtl/game_sequencer_edge_detect.sv
// Registered rising-edge detector: pulse is high for the cycle in which level
// is high and the previous sample was low.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  // NOTE: resetting the sample high means a key already held when reset
  // releases never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RESET_VAL;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Match sequencer: gates game frames, tracks misses/scores and serves the ball
// through IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER).
module game_sequencer
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int LEFT_MISS_X  = 4,
  parameter int RIGHT_MISS_X = SCREEN_H_RES - 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [KEYS_W-1:0]  keys_i,
  input  logic               new_frame_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  output logic               game_frame_o,
  output logic               game_rst_o,
  output logic [2:0]         state_o,
  output logic [SCORE_W-1:0] player_score_o,
  output logic [SCORE_W-1:0] pc_score_o,
  output logic               winner_o
);

  localparam logic [SCORE_W-1:0]     WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_L = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] POINT_L = FRAME_CNT_W'(POINT_FRAMES - 1);

  game_state_t              state;
  logic [FRAME_CNT_W-1:0]   frame_cnt;
  logic [SCORE_W-1:0]       player_score;
  logic [SCORE_W-1:0]       pc_score;
  logic                     game_rst;
  logic                     start_evt;
  logic                     play_strobe;
  logic                     left_miss;
  logic                     right_miss;
  logic                     win_reached;

  edge_detect #(.RESET_VAL(1'b1)) u_start (
    .clk   (clk_i),
    .rst_n (rst_i),
    .level (|keys_i),
    .pulse (start_evt)
  );

  // Left miss wins if both thresholds overlap, so at most one score moves.
  always_comb begin
    play_strobe = new_frame_i && (state == ST_PLAY);
    left_miss   = play_strobe && (ball_x_i < X_POS_W'(LEFT_MISS_X));
    right_miss  = play_strobe && !left_miss && (ball_x_i > X_POS_W'(RIGHT_MISS_X));
    win_reached = (player_score == WIN) || (pc_score == WIN);
  end

  // NOTE: every register below uses <= so all branches see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      frame_cnt    <= '0;
      player_score <= '0;
      pc_score     <= '0;
      game_rst     <= 1'b1;
    end else begin
      game_rst <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_evt) begin
            state        <= ST_SERVE;
            frame_cnt    <= '0;
            player_score <= '0;
            pc_score     <= '0;
            game_rst     <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (new_frame_i) begin
            if (frame_cnt == SERVE_L) begin
              state     <= ST_PLAY;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (left_miss || right_miss) begin
            state     <= ST_POINT;
            frame_cnt <= '0;
          end
          if (left_miss && player_score < WIN) player_score <= player_score + SCORE_W'(1);
          if (right_miss && pc_score < WIN)    pc_score     <= pc_score + SCORE_W'(1);
        end
        ST_POINT: begin
          if (new_frame_i) begin
            if (frame_cnt == POINT_L) begin
              state     <= win_reached ? ST_OVER : ST_SERVE;
              frame_cnt <= '0;
              game_rst  <= !win_reached;
            end else begin
              frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_frame_o   = play_strobe && !left_miss && !right_miss;
  assign game_rst_o     = game_rst;
  assign state_o        = state;
  assign player_score_o = player_score;
  assign pc_score_o     = pc_score;
  assign winner_o       = (state == ST_OVER) && (pc_score == WIN);

endmodule
